// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin front end that sequences requests through a shared 4-bit ALU core
module alu_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req_op0,
    input  logic [3:0] req_op1,
    input  logic [3:0] req_a0,
    input  logic [3:0] req_a1,
    input  logic [3:0] req_b0,
    input  logic [3:0] req_b1,
    output logic [1:0] rsp_valid,
    input  logic [1:0] rsp_ready,
    output logic [7:0] rsp_data,
    output logic [3:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_en,
    input  logic [7:0] alu_out,
    input  logic       err_clr,
    output logic [7:0] err_count,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state_q, state_d;
    logic last_q, last_d, gnt_q, gnt_d, sel, hs;
    logic [3:0] op_q, op_d, a_q, a_d, b_q, b_d;
    logic [7:0] data_q, data_d, err_q, err_d;
    always_comb begin
        // a tie goes to whoever did not win last; a lone requester always wins
        sel = (req_valid == 2'b11) ? ~last_q : req_valid[1];
        hs = (state_q == IDLE) && |req_valid;
        req_ready = hs ? (sel ? 2'b10 : 2'b01) : 2'b00;
        state_d = state_q;
        last_d = last_q;
        gnt_d = gnt_q;
        op_d = op_q;
        a_d = a_q;
        b_d = b_q;
        data_d = data_q;
        err_d = err_clr ? 8'd0 : (state_q == ISSUE && alu_out[4] && err_q != 8'hff) ? err_q + 8'd1 : err_q;
        case (state_q)
            IDLE: if (hs) begin
                state_d = ISSUE;
                last_d = sel;
                gnt_d = sel;
                op_d = sel ? req_op1 : req_op0;
                a_d = sel ? req_a1 : req_a0;
                b_d = sel ? req_b1 : req_b0;
            end
            ISSUE: begin
                state_d = RESP;
                data_d = alu_out;
            end
            RESP: if (rsp_ready[gnt_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q <= 1'b1;
            gnt_q <= 1'b0;
            op_q <= 4'd0;
            a_q <= 4'd0;
            b_q <= 4'd0;
            data_q <= 8'd0;
            err_q <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            gnt_q <= gnt_d;
            op_q <= op_d;
            a_q <= a_d;
            b_q <= b_d;
            data_q <= data_d;
            err_q <= err_d;
        end
    end
    assign alu_op = op_q;
    assign alu_a = a_q;
    assign alu_b = b_q;
    assign alu_en = state_q == ISSUE;
    assign rsp_valid = (state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data = data_q;
    assign err_count = err_q;
    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized scoreboard bench for alu_arbiter with a behavioural ALU core and transaction model
module tb_alu_arbiter;
    logic clk = 0, rst;
    logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [3:0] req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, alu_op, alu_a, alu_b;
    logic [7:0] rsp_data, alu_out, err_count;
    logic alu_en, err_clr, busy;
    int nvec = 0, nerr = 0, cyc = 0, hs_cyc = 0, merr = 0;
    logic mbusy = 0, mlast = 1;
    typedef struct packed {logic idx; logic [3:0] op, a, b; logic [7:0] d;} item_t;
    item_t q[$];

    alu_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
        .req_b0(req_b0), .req_b1(req_b1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_en(alu_en), .alu_out(alu_out), .err_clr(err_clr), .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu(input logic [3:0] op, a, b);
        logic [4:0] s;
        logic [3:0] r;
        logic c, e;
        s = 5'd0; c = 0; e = 0;
        case (op)
            4'd0: begin s = a + b; r = s[3:0]; c = s[4]; end
            4'd1: begin r = a - b; c = a < b; end
            4'd2: r = a * b;
            4'd3: begin e = (b == 0); r = e ? 4'd0 : a / b; end
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd9: r = 4'd0;
            4'd13: r = a ^ b;
            default: r = a;
        endcase
        return {r == 4'd0, c, r[3], e, r};
    endfunction

    function automatic logic [1:0] arb(input logic [1:0] v, input logic last);
        return (v == 2'b11) ? (last ? 2'b01 : 2'b10) : v;
    endfunction

    always_comb alu_out = alu(alu_op, alu_a, alu_b);

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // transaction-level monitor: issues go into the queue, responses are popped on handshake
    always @(negedge clk) begin
        logic b0, ee;
        logic [1:0] er, erv;
        item_t it;
        cyc++;
        if (rst) begin
            q.delete();
            mbusy = 0;
            mlast = 1;
            merr = 0;
        end else begin
            b0 = mbusy;
            er = b0 ? 2'b00 : arb(req_valid, mlast);
            chk("req_ready", {30'd0, req_ready}, {30'd0, er});
            chk("busy", {31'd0, busy}, {31'd0, b0});
            chk("err_count", {24'd0, err_count}, merr);
            ee = b0 && cyc == hs_cyc + 1;
            erv = (b0 && cyc >= hs_cyc + 2) ? (q[0].idx ? 2'b10 : 2'b01) : 2'b00;
            chk("alu_en", {31'd0, alu_en}, {31'd0, ee});
            chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, erv});
            if (b0) chk("alu_opab", {20'd0, alu_op, alu_a, alu_b}, {20'd0, q[0].op, q[0].a, q[0].b});
            if (erv != 0) chk("rsp_data", {24'd0, rsp_data}, {24'd0, q[0].d});
            merr = err_clr ? 0 : (ee && q[0].d[4] && merr != 255) ? merr + 1 : merr;
            if (|(erv & rsp_ready)) begin
                void'(q.pop_front());
                mbusy = 0;
            end
            if (er != 0) begin
                it.idx = er[1];
                it.op = er[1] ? req_op1 : req_op0;
                it.a = er[1] ? req_a1 : req_a0;
                it.b = er[1] ? req_b1 : req_b0;
                it.d = alu(it.op, it.a, it.b);
                q.push_back(it);
                mbusy = 1;
                mlast = er[1];
                hs_cyc = cyc;
            end
        end
    end

    initial begin
        int n;
        rst = 1; req_valid = 0; rsp_ready = 2'b11; err_clr = 0;
        req_op0 = 0; req_op1 = 0; req_a0 = 0; req_a1 = 0; req_b0 = 0; req_b1 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", {rsp_valid, alu_en, busy, req_ready}, 0);
        chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
        chk("rst_data", {rsp_data, err_count}, 0);
        rst = 0;
        req_valid = 2'b01; req_op0 = 0; req_a0 = 7; req_b0 = 9;
        tick;
        req_valid = 0;
        chk("add_en", {31'd0, alu_en}, 1);
        tick;
        chk("add_rsp", {rsp_valid, rsp_data}, {2'b01, 8'b1100_0000});
        chk("add_err", {24'd0, err_count}, 0);
        tick;
        repeat (45) begin
            req_valid = 2'b11; req_op0 = 13; req_op1 = 13;
            req_a0 = 4'($urandom); req_b0 = 4'($urandom); req_a1 = 4'($urandom); req_b1 = 4'($urandom);
            tick;
        end
        req_valid = 0;
        repeat (4) tick;
        req_valid = 2'b10; req_op1 = 3; req_a1 = 5; req_b1 = 0;
        tick;
        req_valid = 0;
        tick;
        chk("div_rsp", {rsp_valid, rsp_data}, {2'b10, 8'b1001_0000});
        chk("div_err", {24'd0, err_count}, 1);
        tick;
        req_valid = 2'b01; req_op0 = 3; req_b0 = 0;
        repeat (910) begin
            req_a0 = 4'($urandom);
            tick;
        end
        chk("err_sat", {24'd0, err_count}, 255);
        n = 0;
        while (!alu_en && n < 10) begin tick; n++; end
        chk("issue_wait", {31'd0, alu_en}, 1);
        err_clr = 1;
        tick;
        err_clr = 0;
        chk("err_clr_wins", {24'd0, err_count}, 0);
        req_valid = 0;
        repeat (4) tick;
        req_valid = 2'b01; req_op0 = 4'($urandom); req_a0 = 4'($urandom); req_b0 = 4'($urandom);
        tick;
        req_valid = 2'b11; rsp_ready = 0;
        repeat (12) tick;
        chk("hold_ready", {30'd0, req_ready}, 0);
        chk("hold_valid", {30'd0, rsp_valid}, 1);
        rsp_ready = 2'b11;
        n = 0;
        while (req_ready == 0 && n < 10) begin tick; n++; end
        chk("hold_grant", {30'd0, req_ready}, 2'b10);
        repeat (400) begin
            req_valid = 2'($urandom); rsp_ready = 2'($urandom);
            req_op0 = 4'($urandom); req_op1 = 4'($urandom);
            req_a0 = 4'($urandom); req_b0 = 4'($urandom_range(0, 3));
            req_a1 = 4'($urandom); req_b1 = 4'($urandom_range(0, 3));
            err_clr = ($urandom_range(0, 15) == 0);
            tick;
        end
        err_clr = 0; rsp_ready = 2'b11; req_valid = 0;
        repeat (4) tick;
        req_valid = 2'b01; req_op0 = 2; req_a0 = 3; req_b0 = 3;
        tick;
        req_valid = 2'b11;
        #5;
        rst = 1;
        #1;
        chk("arst_out", {rsp_valid, alu_en, busy}, 0);
        chk("arst_alu", {alu_op, alu_a, alu_b}, 0);
        chk("arst_data", {rsp_data, err_count}, 0);
        @(posedge clk);
        tick;
        rst = 0;
        chk("arst_tie", {30'd0, req_ready}, 2'b01);
        req_valid = 0;
        repeat (10) tick;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
